burst_read_reg_file: RTL and testbench

BURST_READ_REG_FILE -- requirements
Module: burst_read_reg_file

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/burst_read_reg_file_if.sv | 32 +++
 rtl/reg_file.sv | 23 ++
 rtl/burst_read_reg_file.sv | 103 ++++++++++
 tb/tb_burst_read_reg_file.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings and defaults for the register-file blocks: the swap FSM
// and the burst-read streamer.
package regfile_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    SWAP_IDLE   = 2'd0,
    SWAP_READ_A = 2'd1,
    SWAP_READ_B = 2'd2,
    SWAP_WRITE  = 2'd3
  } swap_state_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } burst_state_t;

endpackage

// File: rtl/burst_read_reg_file_if.sv
// Host write port, burst request and output stream of the burst-read register file.
interface burst_read_reg_file_if
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] address_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  start;
  logic [ADDR_WIDTH-1:0] address_start;
  logic [ADDR_WIDTH:0]   length;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  ready_r;
  logic                  busy;
  logic                  done;

  // Stream handshake: a word transfers on a rising edge where valid_r and
  // ready_r are both 1; while valid_r=1 and ready_r=0, data_r is held and
  // valid_r stays high. valid_r never depends combinationally on ready_r.
  modport master (
    output we, address_w, data_w, start, address_start, length, ready_r,
    input  data_r, valid_r, busy, done
  );

  modport slave (
    input  we, address_w, data_w, start, address_start, length, ready_r,
    output data_r, valid_r, busy, done
  );
endinterface

// File: rtl/reg_file.sv
// Register file with one synchronous write port and one combinational read port.
module reg_file #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/burst_read_reg_file.sv
// Streams a contiguous (wrapping) range of the register file out over a
// valid/ready port while the host keeps write access in every state.
module burst_read_reg_file
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  burst_read_reg_file_if.slave  bus,
  output burst_state_t          state
);

  localparam int LEN_W = ADDR_WIDTH + 1;

  burst_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rd_data;
  logic                  valid_q, valid_d;
  logic                  capture;
  logic                  hs;

  assign hs = valid_q & bus.ready_r;

  // The read port looks at ptr_d, so a capture samples the word at the
  // pointer being loaded on this edge, before any same-edge host write lands.
  reg_file #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reg_file (
    .clk     (clk),
    .we      (bus.we),
    .wr_addr (bus.address_w),
    .wr_data (bus.data_w),
    .rd_addr (ptr_d),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            ptr_d   = bus.address_start;
            rem_d   = bus.length;
            valid_d = 1'b1;
            capture = 1'b1;
            state_d = ST_STREAM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STREAM: begin
        if (hs) begin
          if (rem_q != LEN_W'(1)) begin
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            rem_d   = rem_q - LEN_W'(1);
            capture = 1'b1;
          end else begin
            rem_d   = '0;
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_d = capture ? rd_data : data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_r  = data_q;
  assign bus.valid_r = valid_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_burst_read_reg_file.sv
// Directed bench for burst_read_reg_file: expected stream words go into a
// queue at issue time and a forked monitor pops them on every handshake.
module tb_burst_read_reg_file;
  import regfile_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  burst_state_t state;

  burst_read_reg_file_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  burst_read_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .state   (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int done_seen = 0;
  int done_run = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_model [2**AW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1;
    bus.address_w = a;
    bus.data_w = d;
    mem_model[a] = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic push_model(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem_model[p]);
      p = p + AW'(1);
    end
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [AW:0] n);
    bus.start = 1'b1;
    bus.address_start = a;
    bus.length = n;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_busy"}, 32'(bus.busy), 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 32'(bus.valid_r), 0);
    check({name, "_busy"}, 32'(bus.busy), 0);
    check({name, "_done"}, 32'(bus.done), 0);
    check({name, "_data"}, 32'(bus.data_r), 0);
    check({name, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    bus.we = 1'b0;
    bus.address_w = '0;
    bus.data_w = '0;
    bus.start = 1'b0;
    bus.address_start = '0;
    bus.length = '0;
    bus.ready_r = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (bus.done) begin
          done_seen++;
          done_run++;
          check("done_width", done_run, 1);
        end else begin
          done_run = 0;
        end
        if (bus.valid_r && bus.ready_r) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", bus.data_r);
          end else begin
            check("stream_word", 32'(bus.data_r), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 2**AW; i++) write_word(AW'(i), DW'(i + 8'h10));

    // Basic burst: four words back to back, then a single done pulse.
    bus.ready_r = 1'b1;
    exp_q.push_back(8'h15); exp_q.push_back(8'h16);
    exp_q.push_back(8'h17); exp_q.push_back(8'h18);
    start_burst(7'd5, 8'd4);
    check("first_valid", 32'(bus.valid_r), 1);
    check("first_busy", 32'(bus.busy), 1);
    check("first_data", 32'(bus.data_r), 32'h15);
    repeat (4) tick();
    check("b1_done", 32'(bus.done), 1);
    check("b1_valid_clear", 32'(bus.valid_r), 0);
    check("b1_pending", exp_q.size(), 0);
    tick();
    check("b1_done_fall", 32'(bus.done), 0);
    check("b1_busy_fall", 32'(bus.busy), 0);
    exp_done++;

    // Wrap-around past the top address.
    exp_q.push_back(8'h8E); exp_q.push_back(8'h8F); exp_q.push_back(8'h10);
    start_burst(7'd126, 8'd3);
    wait_idle("wrap");
    exp_done++;

    // Zero-length request.
    start_burst(7'd9, 8'd0);
    check("len0_done", 32'(bus.done), 1);
    check("len0_valid", 32'(bus.valid_r), 0);
    check("len0_busy", 32'(bus.busy), 1);
    tick();
    check("len0_done_fall", 32'(bus.done), 0);
    check("len0_busy_fall", 32'(bus.busy), 0);
    exp_done++;

    // Stall with host writes and a stray start during the burst.
    exp_q.push_back(8'h24); exp_q.push_back(8'h25);
    exp_q.push_back(8'hAA); exp_q.push_back(8'h27);
    start_burst(7'd20, 8'd4);
    check("stall_w0", 32'(bus.data_r), 32'h24);
    tick();
    check("stall_w1", 32'(bus.data_r), 32'h25);
    bus.ready_r = 1'b0;
    bus.we = 1'b1; bus.address_w = 7'd21; bus.data_w = 8'h55; mem_model[21] = 8'h55;
    tick();
    check("stall1_data", 32'(bus.data_r), 32'h25);
    check("stall1_valid", 32'(bus.valid_r), 1);
    bus.address_w = 7'd22; bus.data_w = 8'hAA; mem_model[22] = 8'hAA;
    tick();
    check("stall2_data", 32'(bus.data_r), 32'h25);
    check("stall2_state", 32'(state), 32'(ST_STREAM));
    bus.we = 1'b0;
    bus.start = 1'b1; bus.address_start = 7'd0; bus.length = 8'd5;
    tick();
    bus.start = 1'b0;
    check("stall3_data", 32'(bus.data_r), 32'h25);
    check("stall3_valid", 32'(bus.valid_r), 1);
    bus.ready_r = 1'b1;
    wait_idle("stall");
    exp_done++;

    // Write to the address captured on the same edge returns the old word.
    bus.we = 1'b1; bus.address_w = 7'd40; bus.data_w = 8'h99;
    exp_q.push_back(8'h38); exp_q.push_back(8'h39);
    start_burst(7'd40, 8'd2);
    bus.we = 1'b0;
    mem_model[40] = 8'h99;
    wait_idle("rbw");
    exp_done++;
    exp_q.push_back(8'h99);
    start_burst(7'd40, 8'd1);
    wait_idle("rbw_after");
    exp_done++;

    // Full-depth burst visits every location exactly once.
    push_model(7'd100, 2**AW);
    start_burst(7'd100, 8'd128);
    wait_idle("full");
    exp_done++;

    // Reset while the second word is presented.
    exp_q.push_back(8'h1A); exp_q.push_back(8'h1B);
    exp_q.push_back(8'h1C); exp_q.push_back(8'h1D);
    start_burst(7'd10, 8'd4);
    tick();
    check("pre_reset_w1", 32'(bus.data_r), 32'h1B);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    push_model(7'd18, 6);
    start_burst(7'd18, 8'd6);
    wait_idle("post_reset");
    exp_done++;

    repeat (2) tick();
    check("done_count", done_seen, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
